// File: rtl/imem_load_ctrl.sv
// Sequences the instruction memory: stream-loads a program via valid/ready, then serves bounds-checked fetches.
// Memory writes land one cycle after each accepted word; load_ready is held low outside LOAD and while draining.
module imem_load_ctrl #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run_start,
  input  logic              halt_in,
  input  logic [31:0]       fetch_addr,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              pc_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   word_count,
  output logic [1:0]        state_out,
  output logic              load_err,
  output logic              addr_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_RUN,
    ST_HALTED
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                handshake;
  logic                in_run;
  logic                fetch_ok;

  assign handshake = (state_q == ST_LOAD) && load_valid;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end else if (run_start) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          we_d     = 1'b1;
          waddr_d  = wr_ptr_q;
          wdata_d  = load_data;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          cnt_d    = cnt_q + CNT_ONE;
          if (load_last) begin
            state_d = ST_DRAIN;
          end else if (wr_ptr_q == LAST_IDX) begin
            // memory full with no end marker: stop accepting and flag it
            state_d = ST_DRAIN;
            err_d   = 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_in) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign in_run    = (state_q == ST_RUN);
  assign fetch_ok  = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:2] < 30'(cnt_q));

  assign load_ready = (state_q == ST_LOAD);
  assign pc_stall   = !in_run;
  assign mem_raddr  = fetch_addr[ADDR_W+1:2];
  assign fetch_inst = (in_run && fetch_ok) ? mem_rdata : '0;
  assign addr_err   = in_run && !fetch_ok;
  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = cnt_q;
  assign load_err   = err_q;

  // DRAIN is reported as LOAD to the outside world
  always_comb begin
    state_out = 2'd0;
    case (state_q)
      ST_IDLE:   state_out = 2'd0;
      ST_LOAD:   state_out = 2'd1;
      ST_DRAIN:  state_out = 2'd1;
      ST_RUN:    state_out = 2'd2;
      ST_HALTED: state_out = 2'd3;
      default:   state_out = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed vector table, overflow sequence, then random traffic against a reference model.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        reset, load_start, load_valid, load_last, run_start, halt_in;
  logic [31:0] load_data, fetch_addr;
  logic        load_ready, pc_stall, mem_we, load_err, addr_err;
  logic [31:0] fetch_inst, mem_wdata, mem_rdata;
  logic [4:0]  mem_waddr, mem_raddr;
  logic [5:0]  word_count;
  logic [1:0]  state_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .run_start(run_start), .halt_in(halt_in), .fetch_addr(fetch_addr),
    .fetch_inst(fetch_inst), .pc_stall(pc_stall), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .word_count(word_count), .state_out(state_out),
    .load_err(load_err), .addr_err(addr_err)
  );

  // instruction memory array driven by the DUT's ports
  logic [31:0] mem [32];
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  // reference model: program phase, accepted-word count, pending write, expected memory image
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HALT = 3;
  int          m_phase;
  bit          m_drain;
  int          m_cnt;
  bit          m_err;
  bit          m_we;
  int          m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_mem [32];

  typedef struct {
    bit          rst, ls, lv, last, rs, halt;
    logic [31:0] data, faddr;
    logic [1:0]  e_st;
    bit          e_stall, e_rdy, e_we;
    logic [5:0]  e_wc;
    logic [31:0] e_inst;
    bit          e_aerr;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit          run, legal;
    int          widx;
    logic [31:0] e_inst;
    run   = (m_phase == P_RUN);
    widx  = int'(fetch_addr >> 2);
    legal = (fetch_addr % 4 == 0) && ((fetch_addr >> 2) < 32'(m_cnt));
    e_inst = (run && legal) ? m_mem[widx] : 32'h0;
    chk("mdl_state", state_out, 64'(m_phase));
    chk("mdl_stall", pc_stall, 64'(!run));
    chk("mdl_ready", load_ready, 64'(m_phase == P_LOAD && !m_drain));
    chk("mdl_we", mem_we, 64'(m_we));
    if (m_we) begin
      chk("mdl_waddr", mem_waddr, 64'(m_wa));
      chk("mdl_wdata", mem_wdata, 64'(m_wd));
    end
    chk("mdl_count", word_count, 64'(m_cnt));
    chk("mdl_lerr", load_err, 64'(m_err));
    chk("mdl_raddr", mem_raddr, 64'((fetch_addr >> 2) % 32));
    chk("mdl_inst", fetch_inst, 64'(e_inst));
    chk("mdl_aerr", addr_err, 64'(run && !legal));
  endtask

  task automatic start_load();
    m_phase = P_LOAD;
    m_cnt   = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    if (m_we) m_mem[m_wa] = m_wd;
    if (reset) begin
      m_phase = P_IDLE; m_drain = 1'b0; m_cnt = 0; m_err = 1'b0;
      m_we = 1'b0; m_wa = 0; m_wd = 32'h0;
      return;
    end
    m_we = 1'b0;
    case (m_phase)
      P_IDLE: if (load_start) start_load(); else if (run_start) m_phase = P_RUN;
      P_LOAD: begin
        if (m_drain) begin
          m_drain = 1'b0;
          m_phase = P_RUN;
        end else if (load_valid) begin
          m_we = 1'b1; m_wa = m_cnt; m_wd = load_data;
          m_cnt++;
          if (load_last) m_drain = 1'b1;
          else if (m_cnt == 32) begin m_drain = 1'b1; m_err = 1'b1; end
        end
      end
      P_RUN:  if (halt_in) m_phase = P_HALT;
      default: if (load_start) start_load();
    endcase
  endtask

  task automatic set_in(input vec_t v);
    reset = v.rst; load_start = v.ls; load_valid = v.lv; load_last = v.last;
    run_start = v.rs; halt_in = v.halt; load_data = v.data; fetch_addr = v.faddr;
  endtask

  task automatic tick(input bit use_vec, input vec_t v);
    @(negedge clk);
    model_check();
    if (use_vec) begin
      chk("tbl_state", state_out, 64'(v.e_st));
      chk("tbl_stall", pc_stall, 64'(v.e_stall));
      chk("tbl_ready", load_ready, 64'(v.e_rdy));
      chk("tbl_we", mem_we, 64'(v.e_we));
      chk("tbl_count", word_count, 64'(v.e_wc));
      chk("tbl_inst", fetch_inst, 64'(v.e_inst));
      chk("tbl_aerr", addr_err, 64'(v.e_aerr));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 32; i++) begin mem[i] = 32'h0; m_mem[i] = 32'h0; end
    //          rst ls lv lt rs ht data          faddr  st stl rdy we wc inst          aerr
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 32'h0,        32'd0,  0, 1, 0, 0, 0, 32'h0,        0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 32'h0,        32'd0,  0, 1, 0, 0, 0, 32'h0,        0};
    tbl[2]  = '{0, 0, 1, 0, 0, 0, 32'h0C000004, 32'd0,  1, 1, 1, 0, 0, 32'h0,        0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 32'h8C010004, 32'd0,  1, 1, 1, 1, 1, 32'h0,        0};
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 32'h0000E000, 32'd0,  1, 1, 1, 1, 2, 32'h0,        0};
    tbl[5]  = '{0, 0, 1, 1, 0, 0, 32'hB4221820, 32'd0,  1, 1, 1, 1, 3, 32'h0,        0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd0,  1, 1, 0, 1, 4, 32'h0,        0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd8,  2, 0, 0, 0, 4, 32'h0000E000, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd16, 2, 0, 0, 0, 4, 32'h0,        1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd6,  2, 0, 0, 0, 4, 32'h0,        1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd12, 2, 0, 0, 0, 4, 32'hB4221820, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 1, 32'h0,        32'd0,  2, 0, 0, 0, 4, 32'h0C000004, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd0,  3, 1, 0, 0, 4, 32'h0,        0};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 32'h0,        32'd0,  3, 1, 0, 0, 4, 32'h0,        0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd0,  1, 1, 1, 0, 0, 32'h0,        0};
    tbl[15] = '{0, 0, 1, 0, 0, 0, 32'h11111111, 32'd0,  1, 1, 1, 0, 0, 32'h0,        0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd0,  1, 1, 1, 1, 1, 32'h0,        0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd0,  1, 1, 1, 0, 1, 32'h0,        0};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd0,  1, 1, 1, 0, 1, 32'h0,        0};
    tbl[19] = '{0, 0, 1, 0, 0, 0, 32'h22222222, 32'd0,  1, 1, 1, 0, 1, 32'h0,        0};
    tbl[20] = '{1, 0, 1, 0, 0, 0, 32'h33333333, 32'd0,  1, 1, 1, 1, 2, 32'h0,        0};
    tbl[21] = '{0, 0, 1, 0, 0, 0, 32'h33333333, 32'd0,  0, 1, 0, 0, 0, 32'h0,        0};
    tbl[22] = '{0, 0, 0, 0, 1, 0, 32'h0,        32'd0,  0, 1, 0, 0, 0, 32'h0,        0};
    tbl[23] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'd0,  2, 0, 0, 0, 0, 32'h0,        1};

    // unchecked power-on reset cycle; the model starts from the reset state
    v = tbl[0];
    set_in(v);
    @(posedge clk);
    #1;
    m_phase = P_IDLE; m_drain = 1'b0; m_cnt = 0; m_err = 1'b0;
    m_we = 1'b0; m_wa = 0; m_wd = 32'h0;

    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i]);
      tick(1'b1, tbl[i]);
    end

    // overflow: 32 words with no end marker
    v = tbl[22]; v.rs = 1'b0; v.halt = 1'b1;
    set_in(v); tick(1'b0, v);
    v.halt = 1'b0; v.ls = 1'b1;
    set_in(v); tick(1'b0, v);
    v.ls = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v.lv = 1'b1; v.data = 32'hA0000000 + 32'(i);
      set_in(v); tick(1'b0, v);
    end
    v.lv = 1'b0;
    set_in(v); tick(1'b0, v);
    v = '{0, 0, 0, 0, 0, 0, 32'h0, 32'd124, 2, 0, 0, 0, 32, 32'hA000001F, 0};
    set_in(v); tick(1'b1, v);
    chk("ovf_load_err", load_err, 64'd1);
    v = '{0, 0, 0, 0, 0, 0, 32'h0, 32'd128, 2, 0, 0, 0, 32, 32'h0, 1};
    set_in(v); tick(1'b1, v);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      v.rst  = ($urandom_range(0, 99) == 0);
      v.ls   = ($urandom_range(0, 9) == 0);
      v.rs   = ($urandom_range(0, 9) == 0);
      v.halt = ($urandom_range(0, 19) == 0);
      v.lv   = ($urandom_range(0, 9) < 6);
      v.last = ($urandom_range(0, 9) == 0);
      v.data = $urandom;
      case ($urandom_range(0, 3))
        0: v.faddr = 32'($urandom_range(0, 33)) * 4;
        1: v.faddr = 32'($urandom_range(0, 140));
        2: v.faddr = $urandom;
        default: v.faddr = 32'($urandom_range(0, 31)) * 4;
      endcase
      set_in(v);
      tick(1'b0, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
